// File: rtl/sd_dfc_tx.sv
// Transmit side of a delayed-flow-control link: srdy/drdy producer in, registered c_vld/c_data out.
// A 2-entry skid buffer decouples p_drdy from c_fc_n; launches stop 1+regcin cycles after c_fc_n falls.
module sd_dfc_tx #(
   parameter int width  = 8,
   parameter int regcin = 1,
   parameter int cnt_w  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p_srdy,
   output logic             p_drdy,
   input  logic [width-1:0] p_data,
   output logic             c_vld,
   output logic [width-1:0] c_data,
   input  logic             c_fc_n,
   input  logic             force_stop,
   input  logic             stall_clr,
   output logic [cnt_w-1:0] stall_cnt,
   output logic             busy
);

   // Producer handshake: an item transfers on a clock edge where p_srdy and p_drdy are both 1.
   // p_drdy depends only on the occupancy flops, so the receiver's c_fc_n never reaches it.

   logic [width-1:0] mem [2];
   logic             hd;
   logic             tl;
   logic [1:0]       cnt;
   logic             fc_q;
   logic             fc_src;
   logic             fc_ok;
   logic             push;
   logic             launch;

   assign p_drdy = (cnt != 2'd2);
   assign busy   = (cnt != 2'd0);
   assign push   = p_srdy & p_drdy;
   assign fc_src = (regcin != 0) ? fc_q : c_fc_n;
   assign fc_ok  = fc_src & ~force_stop;
   // No bypass: only buffered items launch, so every item sits in the buffer at least one cycle.
   assign launch = fc_ok & busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         fc_q <= 1'b0;
      end else begin
         fc_q <= c_fc_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hd  <= 1'b0;
         tl  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (push) begin
            tl <= ~tl;
         end
         if (launch) begin
            hd <= ~hd;
         end
         cnt <= cnt + {1'b0, push} - {1'b0, launch};
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tl] <= p_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_vld <= 1'b0;
      end else begin
         c_vld <= launch;
      end
   end

   always_ff @(posedge clk) begin
      if (launch) begin
         c_data <= mem[hd];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (busy & ~fc_ok & ~(&stall_cnt)) begin
         stall_cnt <= stall_cnt + cnt_w'(1);
      end
   end

endmodule

// File: tb/tb_sd_dfc_tx.sv
// Bench for sd_dfc_tx: one instance with regcin=1/cnt_w=4 and one with regcin=0/cnt_w=16, same stimulus.
// A queue-based reference model tracks each instance; directed tables and sequences cover the corner cases.
module tb_sd_dfc_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       p_srdy;
   logic [7:0] p_data;
   logic       c_fc_n;
   logic       force_stop;
   logic       stall_clr;

   logic        p_drdy_a, c_vld_a, busy_a;
   logic [7:0]  c_data_a;
   logic [3:0]  stall_a;
   logic        p_drdy_b, c_vld_b, busy_b;
   logic [7:0]  c_data_b;
   logic [15:0] stall_b;

   int checks = 0;
   int errors = 0;

   // reference model state: exp_q holds items accepted but not yet launched
   logic [7:0] exp_q [2][$];
   logic       m_vld [2];
   logic [7:0] m_data [2];
   logic       m_fcq [2];
   int         m_stall [2];
   int         m_max [2] = '{15, 65535};

   typedef struct {
      logic       srdy;
      logic [7:0] data;
      logic       fc_n;
      logic       exp_vld;
      logic [7:0] exp_data;
      logic       exp_drdy;
   } vec_t;
   vec_t tbl [16];

   always #5 clk = ~clk;

   sd_dfc_tx #(.width(8), .regcin(1), .cnt_w(4)) dut_a (
      .clk(clk), .rst(rst), .p_srdy(p_srdy), .p_drdy(p_drdy_a), .p_data(p_data),
      .c_vld(c_vld_a), .c_data(c_data_a), .c_fc_n(c_fc_n), .force_stop(force_stop),
      .stall_clr(stall_clr), .stall_cnt(stall_a), .busy(busy_a)
   );

   sd_dfc_tx #(.width(8), .regcin(0), .cnt_w(16)) dut_b (
      .clk(clk), .rst(rst), .p_srdy(p_srdy), .p_drdy(p_drdy_b), .p_data(p_data),
      .c_vld(c_vld_b), .c_data(c_data_b), .c_fc_n(c_fc_n), .force_stop(force_stop),
      .stall_clr(stall_clr), .stall_cnt(stall_b), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model using the inputs present before the coming edge.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         logic src, ok, push, launch;
         int sz;
         sz     = exp_q[i].size();
         src    = (i == 0) ? m_fcq[i] : c_fc_n;
         ok     = src & ~force_stop;
         push   = p_srdy && (sz < 2);
         launch = ok && (sz != 0);
         if (rst) begin
            exp_q[i].delete();
            m_vld[i]   = 1'b0;
            m_fcq[i]   = 1'b0;
            m_stall[i] = 0;
         end else begin
            if (stall_clr) m_stall[i] = 0;
            else if (sz != 0 && !ok && m_stall[i] < m_max[i]) m_stall[i]++;
            if (launch) begin
               m_data[i] = exp_q[i].pop_front();
               m_vld[i]  = 1'b1;
            end else begin
               m_vld[i] = 1'b0;
            end
            if (push) exp_q[i].push_back(p_data);
            m_fcq[i] = c_fc_n;
         end
      end
   endtask

   task automatic model_check();
      chk("a_vld", 32'(c_vld_a), 32'(m_vld[0]));
      if (m_vld[0]) chk("a_data", 32'(c_data_a), 32'(m_data[0]));
      chk("a_drdy", 32'(p_drdy_a), 32'(exp_q[0].size() < 2));
      chk("a_busy", 32'(busy_a), 32'(exp_q[0].size() != 0));
      chk("a_stall", 32'(stall_a), m_stall[0]);
      chk("b_vld", 32'(c_vld_b), 32'(m_vld[1]));
      if (m_vld[1]) chk("b_data", 32'(c_data_b), 32'(m_data[1]));
      chk("b_drdy", 32'(p_drdy_b), 32'(exp_q[1].size() < 2));
      chk("b_busy", 32'(busy_b), 32'(exp_q[1].size() != 0));
      chk("b_stall", 32'(stall_b), m_stall[1]);
   endtask

   // One clock: inputs are already set; outputs are sampled 1 time unit after the edge.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      model_check();
   endtask

   initial begin
      int zeros;
      rst = 1'b1; p_srdy = 1'b0; p_data = 8'h00; c_fc_n = 1'b0;
      force_stop = 1'b0; stall_clr = 1'b0;
      step();
      step();
      chk("rst_vld", 32'(c_vld_a), 32'd0);
      chk("rst_drdy", 32'(p_drdy_a), 32'd1);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_stall", 32'(stall_a), 32'd0);
      rst = 1'b0;

      // streaming, fc stop at row 4, resume at row 10 (expectations are for the regcin=1 instance)
      tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      tbl[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      tbl[2]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h00, 1'b1};
      tbl[3]  = '{1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 1'b1};
      tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1};
      tbl[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[10] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[11] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h03, 1'b1};
      tbl[12] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h04, 1'b1};
      tbl[13] = '{1'b1, 8'h06, 1'b1, 1'b1, 8'h05, 1'b1};
      tbl[14] = '{1'b0, 8'h06, 1'b1, 1'b1, 8'h06, 1'b1};
      tbl[15] = '{1'b0, 8'h06, 1'b1, 1'b0, 8'h00, 1'b1};
      for (int r = 0; r < 16; r++) begin
         p_srdy = tbl[r].srdy; p_data = tbl[r].data; c_fc_n = tbl[r].fc_n;
         step();
         chk("tbl_vld", 32'(c_vld_a), 32'(tbl[r].exp_vld));
         if (tbl[r].exp_vld) chk("tbl_data", 32'(c_data_a), 32'(tbl[r].exp_data));
         chk("tbl_drdy", 32'(p_drdy_a), 32'(tbl[r].exp_drdy));
      end

      // force_stop pulse of 3 cycles during steady streaming
      c_fc_n = 1'b1; p_srdy = 1'b1; stall_clr = 1'b1; p_data = 8'h10;
      step();
      stall_clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (p_drdy_a) p_data = p_data + 8'd1;
         step();
      end
      zeros = 0;
      for (int k = 0; k < 9; k++) begin
         force_stop = (k < 3);
         p_data = p_data + 8'd1;
         step();
         if (c_vld_a !== 1'b1) zeros++;
      end
      force_stop = 1'b0;
      chk("fstop_gaps", 32'(zeros), 32'd3);
      chk("fstop_stall_a", 32'(stall_a), 32'd3);
      chk("fstop_stall_b", 32'(stall_b), 32'd3);

      // saturation of the 4-bit counter while blocked
      stall_clr = 1'b1; c_fc_n = 1'b0; p_srdy = 1'b1; p_data = 8'h40;
      step();
      stall_clr = 1'b0; p_srdy = 1'b0;
      for (int k = 0; k < 20; k++) step();
      chk("sat_stall", 32'(stall_a), 32'd15);
      step();
      chk("sat_hold", 32'(stall_a), 32'd15);
      stall_clr = 1'b1;
      step();
      chk("clr_stall", 32'(stall_a), 32'd0);
      stall_clr = 1'b0;

      // reset with a full buffer, then one item through
      p_srdy = 1'b1; p_data = 8'h77;
      for (int k = 0; k < 3; k++) step();
      chk("pre_rst_full", 32'(p_drdy_a), 32'd0);
      rst = 1'b1; c_fc_n = 1'b1;
      step();
      chk("mid_rst_vld", 32'(c_vld_a), 32'd0);
      chk("mid_rst_drdy", 32'(p_drdy_a), 32'd1);
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_stall", 32'(stall_a), 32'd0);
      rst = 1'b0; p_srdy = 1'b1; p_data = 8'hA5;
      step();
      p_srdy = 1'b0;
      step();
      chk("post_rst_vld_a", 32'(c_vld_a), 32'd1);
      chk("post_rst_data_a", 32'(c_data_a), 32'hA5);
      chk("post_rst_vld_b", 32'(c_vld_b), 32'd1);
      chk("post_rst_data_b", 32'(c_data_b), 32'hA5);

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         p_srdy     = ($urandom_range(0, 3) != 0);
         p_data     = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) c_fc_n = ~c_fc_n;
         force_stop = ($urandom_range(0, 15) == 0);
         stall_clr  = ($urandom_range(0, 63) == 0);
         rst        = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_dfc_tx.md
Name: sd_dfc_tx

Overview:
Transmit-side converter from srdy/drdy protocol to delayed flow control (DFC). It is the stage directly upstream of the DFC receiver across a registered, multi-cycle channel. A 2-entry input skid buffer keeps p_drdy free of any combinational path from c_fc_n. Output c_vld/c_data are always flopped. Launches stop a fixed, documented number of cycles after the receiver deasserts c_fc_n.

Parameters:
width, 8, datapath width of p_data/c_data
regcin, 1, if 1 register c_fc_n input before use; if 0 use pin directly
cnt_w, 16, width of stall_cnt statistics counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
p_srdy  input  1  producer data valid
p_drdy  output  1  producer ready; driven from state flops only
p_data  input  width  producer data
c_vld  output  1  channel valid, registered
c_data  output  width  channel data, registered
c_fc_n  input  1  channel flow control from receiver; 1 = may send
force_stop  input  1  local override; 1 = no launches
stall_clr  input  1  synchronous clear of stall_cnt
stall_cnt  output  cnt_w  saturating count of cycles with data held but launch blocked
busy  output  1  skid buffer non-empty (cnt != 0)

Behaviour:
- Reset values: c_vld=0, p_drdy=1 (cnt=0), stall_cnt=0, busy=0, fc_q=0. c_data is not reset.
- fc_q flop: fc_q <= c_fc_n. fc_src = regcin ? fc_q : c_fc_n.
- fc_ok = fc_src & ~force_stop. force_stop is combinational and is not flopped.
- Skid buffer: 2 entries with head/tail pointers (1 bit each) and a 2-bit occupancy cnt in 0..2.
  - p_drdy = (cnt != 2).
  - push = p_srdy & p_drdy.
- launch = fc_ok & (cnt != 0).
  - On launch: pop the head, set c_vld<=1, and set c_data<=head data.
  - Otherwise: c_vld<=0 and c_data holds its value.
- cnt_next = cnt + push - launch.
  - Push and launch together at cnt=1: cnt stays 1 and FIFO order is preserved.
  - At cnt=2, push cannot occur.
  - At cnt=0, launch cannot occur. There is no bypass, so an item always spends at least one cycle in the buffer.
- Latency, empty buffer, fc_ok=1: item accepted at edge N is launched in cycle N+1 and is visible as c_vld=1 in cycle N+2.
  - Sustained throughput is 1 item/cycle while fc_ok=1 and p_srdy=1.
- Stop latency: c_fc_n falls in cycle T.
  - regcin=1: the last c_vld=1 appears in cycle T+1, and c_vld=0 from T+2.
  - regcin=0: c_vld=0 from T+1.
  - The transmitter therefore contributes 1+regcin cycles to the round trip. The receiver depth must include this.
- Resume latency: c_fc_n rises in cycle T; c_vld is earliest 1 in T+1+regcin.
- force_stop asserted in cycle T: no launch in T, so c_vld=0 in T+1. Items stay buffered and none are lost or duplicated.
- stall_cnt:
  - stall_clr has priority: stall_cnt <= 0.
  - Else if (cnt != 0) & ~fc_ok: increment, saturating at all-ones.
  - Else hold.
- busy = (cnt != 0), from flops.
- Reset mid-operation: buffer contents are discarded, cnt=0, and c_vld=0 from the cycle after rst is sampled. Producer data accepted before reset is lost by design.
- No X on c_vld after reset, independent of p_data/c_data contents.

Test Plan:
1. Streaming: c_fc_n=1, p_srdy=1 for 10 cycles with p_data=0..9 -> c_vld=1 for 10 consecutive cycles starting 2 cycles after the first accept; c_data=0..9 in order; p_drdy stays 1.
2. Flow-control stop (regcin=1): streaming, then c_fc_n=0 at cycle T -> c_vld=1 in T+1, 0 from T+2; buffer fills to 2 and p_drdy=0. Raise c_fc_n at T+6 -> c_vld resumes at T+8 with no gaps, drops or duplicates in sequence.
3. regcin=0 variant of scenario 2 -> c_vld=0 from T+1; resume visible at T+7.
4. force_stop pulse for 3 cycles during streaming with c_fc_n=1 -> exactly 3 c_vld=0 cycles, each delayed by 1; stall_cnt increments by 3; data order intact.
5. stall_cnt saturation with cnt_w=4: hold c_fc_n=0 with a buffered item for 20 cycles -> stall_cnt=15 and holds. Pulse stall_clr -> 0 next cycle.
6. Reset mid-stream with cnt=2 -> next cycle c_vld=0, p_drdy=1, busy=0, stall_cnt=0. First post-reset item is launched normally after the 2-cycle latency.
